// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the program sequencer: the opcode values it decodes
// in S_NEXT and the encodings of its control states.
package pc_seq_pkg;

    localparam logic [4:0] OPC_BZ   = 5'h10;
    localparam logic [4:0] OPC_BNZ  = 5'h11;
    localparam logic [4:0] OPC_BRA  = 5'h12;
    localparam logic [4:0] OPC_CALL = 5'h13;
    localparam logic [4:0] OPC_RET  = 5'h14;
    localparam logic [4:0] OPC_HALT = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_NEXT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack
// Return-address LIFO for CALL/RET. The parent decides when to push and pop,
// so this block never sees an illegal push-when-full or pop-when-empty.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears sp only)
//   push, pop  : one-cycle strobes from the parent
//   din        : return address to push
//   dout       : combinational top-of-stack (0 when empty)
//   sp         : occupancy, 0..STACK_DEPTH
//   full,empty : occupancy flags
module pc_ret_stack #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                din,
    output logic [ADDR_W-1:0]                dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             full,
    output logic                             empty
);
    import pc_seq_pkg::*;

    localparam int SP_W = $clog2(STACK_DEPTH+1);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    // Storage has no reset: an entry is only ever read after it was pushed.
    // The slot written is the one sp currently points at.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && sp == SP_W'(i)) begin
                mem[i] <= din;
            end
        end
    end

    // Occupancy counter; push and pop are never requested together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Top of stack is the entry just below sp.
    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) begin
                dout = mem[i];
            end
        end
    end

    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program sequencer between the synchronous instruction ROM and the decoder.
// Each instruction takes FETCH, LOAD, (STEP_CYCLES-3) EXEC cycles and NEXT;
// NEXT resolves BZ/BNZ/BRA/CALL/RET/HALT and updates pc.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   z           : ALU zero flag, captured every NEXT
//   stall       : holds the EXEC step counter while high (EXEC only)
//   rom_data    : ROM read data, valid one cycle after rom_addr
//   rom_addr    : ROM address, always equal to pc
//   instr       : registered instruction word to the decoder
//   instr_valid : one-cycle pulse in the first EXEC cycle
//   pc_out      : current pc
//   sp          : return-stack occupancy
//   halted      : high while in S_HALT
//   err         : sticky, bit0 stack overflow, bit1 stack underflow
module pc_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int INSTR_W     = 49,
    parameter int OPC_W       = 5,
    parameter int STEP_CYCLES = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             z,
    input  logic                             stall,
    input  logic [INSTR_W-1:0]               rom_data,
    output logic [ADDR_W-1:0]                rom_addr,
    output logic [INSTR_W-1:0]               instr,
    output logic                             instr_valid,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             halted,
    output logic [1:0]                       err
);
    import pc_seq_pkg::*;

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 4);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pc;
    logic              z_flag;

    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;

    assign opc    = instr[INSTR_W-1 -: OPC_W];
    assign tgt    = instr[ADDR_W-1:0];
    assign pc_inc = pc + ADDR_W'(1);

    // Stack strobes are qualified here so overflow/underflow never reach it.
    assign stk_push = (state == S_NEXT) && (opc == OPC_W'(OPC_CALL)) && !stk_full;
    assign stk_pop  = (state == S_NEXT) && (opc == OPC_W'(OPC_RET))  && !stk_empty;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Main sequencer. z_flag is sampled in NEXT after the branch decision,
    // so a branch always tests the flag left by the previous instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            cnt         <= '0;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            z_flag      <= 1'b0;
            halted      <= 1'b0;
            err         <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    instr       <= rom_data;
                    instr_valid <= 1'b1;
                    cnt         <= '0;
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    instr_valid <= 1'b0;
                    if (!stall) begin
                        if (cnt == CNT_LAST) begin
                            state <= S_NEXT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    z_flag <= z;
                    state  <= S_FETCH;
                    case (opc)
                        OPC_W'(OPC_BZ):   pc <= z_flag ? tgt : pc_inc;
                        OPC_W'(OPC_BNZ):  pc <= !z_flag ? tgt : pc_inc;
                        OPC_W'(OPC_BRA):  pc <= tgt;
                        OPC_W'(OPC_CALL): begin
                            if (stk_full) begin
                                err[0] <= 1'b1;
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                pc <= tgt;
                            end
                        end
                        OPC_W'(OPC_RET): begin
                            if (stk_empty) begin
                                err[1] <= 1'b1;
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                pc <= stk_top;
                            end
                        end
                        OPC_W'(OPC_HALT): begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                S_HALT: begin
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign rom_addr = pc;
    assign pc_out   = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench: a ROM model feeds the sequencer, each scenario writes a
// short program and pushes the expected (address, sp, word) of every executed
// instruction; a monitor pops and compares on each instr_valid pulse.
module tb_pc_sequencer;

    localparam int ADDR_W = 6;
    localparam int INSTR_W = 49;
    localparam int SP_W = 3;

    localparam logic [4:0] NOP  = 5'h00;
    localparam logic [4:0] BZ   = 5'h10;
    localparam logic [4:0] BNZ  = 5'h11;
    localparam logic [4:0] BRA  = 5'h12;
    localparam logic [4:0] CALL = 5'h13;
    localparam logic [4:0] RET  = 5'h14;
    localparam logic [4:0] HLT  = 5'h1F;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               z = 1'b0;
    logic               stall = 1'b0;
    logic [INSTR_W-1:0] rom_data = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc_out;
    logic [SP_W-1:0]    sp;
    logic               halted;
    logic [1:0]         err;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [SP_W-1:0]    sp;
        logic [INSTR_W-1:0] ins;
    } exp_t;

    exp_t               q[$];
    exp_t               e;
    logic [INSTR_W-1:0] rom [64];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 prevCyc = 0;
    int                 lastGap = 0;
    int                 pulseCnt = 0;

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .INSTR_W     (INSTR_W),
        .OPC_W       (5),
        .STEP_CYCLES (5),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .z           (z),
        .stall       (stall),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .sp          (sp),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard side: every decoder handoff is matched against the next
    // expected instruction.
    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            pulseCnt++;
            lastGap = cyc - prevCyc;
            prevCyc = cyc;
            if (q.size() > 0) begin
                e = q.pop_front();
                checkOutput("pc", 64'(pc_out), 64'(e.addr));
                checkOutput("rom_addr", 64'(rom_addr), 64'(e.addr));
                checkOutput("sp", 64'(sp), 64'(e.sp));
                checkOutput("instr", 64'(instr), 64'(e.ins));
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] a, input logic [4:0] opc, input logic [5:0] tgt);
        rom[a] = {opc, 32'($urandom()), 6'd0, tgt};
    endtask

    task automatic expectStep(input logic [5:0] a, input logic [SP_W-1:0] s);
        q.push_back('{a, s, rom[a]});
    endtask

    task automatic startRun();
        rst_n = 1'b0;
        stall = 1'b0;
        z = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 64; i++) applyStimulus(6'(i), NOP, 6'(i));
        q.delete();
        pulseCnt = 0;
    endtask

    task automatic releaseRun();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) checkOutput("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitPc(input logic [5:0] a, input int budget);
        bit found = 0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            #1;
            if (instr_valid && pc_out == a) found = 1;
        end
        if (!found) checkOutput("wait_pc_timeout", 64'(pc_out), 64'(a));
    endtask

    task automatic branchRun(input logic [4:0] opc, input logic zv, input logic [5:0] tgt,
                             input logic [5:0] nxt);
        startRun();
        applyStimulus(6'd3, opc, tgt);
        z = zv;
        for (int i = 0; i < 4; i++) expectStep(6'(i), 3'd0);
        expectStep(nxt, 3'd0);
        expectStep(nxt + 6'd1, 3'd0);
        releaseRun();
        waitDrain(200);
        checkOutput("branch_pulses", 64'(pulseCnt), 64'd6);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state and linear flow.
        startRun();
        #1;
        checkOutput("rst_pc", 64'(pc_out), 64'd0);
        checkOutput("rst_instr", 64'(instr), 64'd0);
        checkOutput("rst_valid", 64'(instr_valid), 64'd0);
        checkOutput("rst_sp", 64'(sp), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) expectStep(6'(i), 3'd0);
        releaseRun();
        @(posedge clk);
        #1;
        checkOutput("valid_early", 64'(instr_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("valid_first", 64'(instr_valid), 64'd1);
        waitDrain(200);
        checkOutput("linear_gap", 64'(lastGap), 64'd5);
        checkOutput("linear_pulses", 64'(pulseCnt), 64'd4);

        // Conditional and unconditional branches.
        branchRun(BZ, 1'b1, 6'd9, 6'd9);
        branchRun(BZ, 1'b0, 6'd9, 6'd4);
        branchRun(BNZ, 1'b0, 6'd9, 6'd9);
        branchRun(BNZ, 1'b1, 6'd9, 6'd4);
        branchRun(BRA, 1'($urandom_range(0, 1)), 6'h2A, 6'd42);

        // Call and return.
        startRun();
        applyStimulus(6'd5, CALL, 6'd20);
        applyStimulus(6'd20, RET, 6'd0);
        for (int i = 0; i < 6; i++) expectStep(6'(i), 3'd0);
        expectStep(6'd20, 3'd1);
        expectStep(6'd6, 3'd0);
        expectStep(6'd7, 3'd0);
        releaseRun();
        waitDrain(300);
        checkOutput("callret_pulses", 64'(pulseCnt), 64'd9);
        checkOutput("callret_err", 64'(err), 64'd0);

        // Four nested calls fit, the fifth overflows and halts.
        startRun();
        for (int i = 0; i < 5; i++) applyStimulus(6'(i * 10), CALL, 6'((i + 1) * 10));
        for (int i = 0; i < 5; i++) expectStep(6'(i * 10), 3'(i));
        releaseRun();
        waitDrain(300);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("ovf_err", 64'(err), 64'd1);
        checkOutput("ovf_halted", 64'(halted), 64'd1);
        checkOutput("ovf_pc", 64'(pc_out), 64'd40);
        checkOutput("ovf_sp", 64'(sp), 64'd4);
        checkOutput("ovf_pulses", 64'(pulseCnt), 64'd5);
        // Asynchronous reset out of the halted/error state.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_err", 64'(err), 64'd0);
        checkOutput("arst_halted", 64'(halted), 64'd0);
        checkOutput("arst_sp", 64'(sp), 64'd0);
        checkOutput("arst_pc", 64'(pc_out), 64'd0);

        // Return with an empty stack.
        startRun();
        applyStimulus(6'd0, RET, 6'd33);
        expectStep(6'd0, 3'd0);
        releaseRun();
        waitDrain(100);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("udf_err", 64'(err), 64'd2);
        checkOutput("udf_halted", 64'(halted), 64'd1);
        checkOutput("udf_pc", 64'(pc_out), 64'd0);

        // HALT opcode: nothing more is handed to the decoder.
        startRun();
        applyStimulus(6'd1, HLT, 6'd12);
        expectStep(6'd0, 3'd0);
        expectStep(6'd1, 3'd0);
        releaseRun();
        waitDrain(100);
        for (int i = 0; i < 50; i++) begin
            z = 1'($urandom());
            stall = 1'($urandom());
            @(posedge clk);
        end
        #1;
        checkOutput("halt_pulses", 64'(pulseCnt), 64'd2);
        checkOutput("halt_halted", 64'(halted), 64'd1);
        checkOutput("halt_pc", 64'(pc_out), 64'd1);
        checkOutput("halt_err", 64'(err), 64'd0);

        // Stall stretches one step from 5 to 12 clocks.
        startRun();
        for (int i = 0; i < 4; i++) expectStep(6'(i), 3'd0);
        releaseRun();
        waitPc(6'd1, 100);
        stall = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        stall = 1'b0;
        waitPc(6'd2, 100);
        checkOutput("stall_gap", 64'(lastGap), 64'd12);
        waitDrain(100);
        checkOutput("stall_pulses", 64'(pulseCnt), 64'd4);

        // pc+1 wraps from the last address to 0.
        startRun();
        applyStimulus(6'd0, BRA, 6'd62);
        expectStep(6'd0, 3'd0);
        expectStep(6'd62, 3'd0);
        expectStep(6'd63, 3'd0);
        expectStep(6'd0, 3'd0);
        releaseRun();
        waitDrain(200);
        checkOutput("wrap_pulses", 64'(pulseCnt), 64'd4);

        // Asynchronous reset mid-EXEC with two return addresses stacked.
        startRun();
        applyStimulus(6'd0, CALL, 6'd10);
        applyStimulus(6'd10, CALL, 6'd20);
        expectStep(6'd0, 3'd0);
        expectStep(6'd10, 3'd1);
        expectStep(6'd20, 3'd2);
        releaseRun();
        waitPc(6'd20, 200);
        checkOutput("mid_sp", 64'(sp), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rom_addr", 64'(rom_addr), 64'd0);
        checkOutput("mid_pc", 64'(pc_out), 64'd0);
        checkOutput("mid_instr", 64'(instr), 64'd0);
        checkOutput("mid_valid", 64'(instr_valid), 64'd0);
        checkOutput("mid_sp_rst", 64'(sp), 64'd0);
        checkOutput("mid_halted", 64'(halted), 64'd0);
        checkOutput("mid_err", 64'(err), 64'd0);
        q.delete();
        pulseCnt = 0;
        expectStep(6'd0, 3'd0);
        expectStep(6'd10, 3'd1);
        releaseRun();
        waitDrain(100);
        checkOutput("restart_pulses", 64'(pulseCnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
